led_pwm_ctrl: RTL and testbench



---
 rtl/led_pwm_ctrl.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_led_pwm_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_pwm_ctrl.sv
// -----------------------------------------------------------------------------
// led_pwm_ctrl
//
// Multi-channel LED driver. A shared prescaler and PWM period counter serve
// all channels. Each channel is OFF, ON, fixed-duty PWM or BREATHE (a
// triangular duty ramp that advances once per PWM period). Configuration
// goes into a per-channel shadow register. It is copied to the active
// register only at a PWM period boundary, so a running waveform never
// glitches.
//
// Optional build macro: LED_GAMMA_EN
//   defined   : the compare value for PWM/BREATHE is (v*v) >> PWM_W, giving a
//               perceptual gamma of about 2. The compare value is
//               pipelined, so led_out lags pwm_cnt by 2 cycles.
//   undefined : linear compare value, led_out lags pwm_cnt by 1 cycle.
//
// Ports
//   clk25        in   system clock (25 MHz)
//   fpga_rst_n   in   asynchronous active-low reset
//   cfg_valid    in   config write request
//   cfg_ready    out  shadow slot of cfg_ch is free (always 1 for bad cfg_ch)
//   cfg_ch       in   target channel index
//   cfg_mode     in   0 OFF, 1 ON, 2 PWM, 3 BREATHE
//   cfg_duty     in   PWM duty, or BREATHE ramp step per period
//   cfg_err      out  one-cycle pulse after a write to cfg_ch >= CH_NUM
//   led_out      out  LED drive, active level set by LED_ACT_LOW
//   period_tick  out  one-cycle pulse after each PWM period end
// -----------------------------------------------------------------------------
module led_pwm_ctrl #(
    parameter int CH_NUM      = 4,
    parameter int PWM_W       = 8,
    parameter int PRESC_DIV   = 96,
    parameter bit LED_ACT_LOW = 1'b0
) (
    input  logic              clk25,
    input  logic              fpga_rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [3:0]        cfg_ch,
    input  logic [1:0]        cfg_mode,
    input  logic [PWM_W-1:0]  cfg_duty,
    output logic              cfg_err,
    output logic [CH_NUM-1:0] led_out,
    output logic              period_tick
);

    localparam int PRESC_W = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESC_DIV - 1);
    localparam logic [PWM_W-1:0]   LVL_MAX    = {PWM_W{1'b1}};
    localparam logic [PWM_W:0]     ONE_EXT    = {{PWM_W{1'b0}}, 1'b1};

    localparam logic [1:0] MODE_OFF     = 2'd0;
    localparam logic [1:0] MODE_ON      = 2'd1;
    localparam logic [1:0] MODE_PWM     = 2'd2;
    localparam logic [1:0] MODE_BREATHE = 2'd3;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // One breathe step: returns {next_dir, next_lvl}. The arithmetic is one
    // bit wider than the level, so the saturation compare never wraps.
    function automatic logic [PWM_W:0] ramp_f(
        input logic [PWM_W-1:0] lvl,
        input logic             dir,
        input logic [PWM_W-1:0] duty
    );
        logic [PWM_W:0] step;
        logic [PWM_W:0] sum;
        logic [PWM_W:0] res;
        step = (duty == {PWM_W{1'b0}}) ? ONE_EXT : {1'b0, duty};
        sum  = {1'b0, lvl} + step;
        if (dir == DIR_UP) begin
            if (sum >= {1'b0, LVL_MAX}) begin
                res = {DIR_DOWN, LVL_MAX};
            end else begin
                res = {DIR_UP, sum[PWM_W-1:0]};
            end
        end else begin
            if ({1'b0, lvl} <= step) begin
                res = {DIR_UP, {PWM_W{1'b0}}};
            end else begin
                res = {DIR_DOWN, lvl - step[PWM_W-1:0]};
            end
        end
        return res;
    endfunction

`ifdef LED_GAMMA_EN
    // Gamma ~2: square the value at full width and keep the upper half.
    function automatic logic [PWM_W-1:0] gamma_f(input logic [PWM_W-1:0] v);
        logic [2*PWM_W-1:0] sq;
        sq = {{PWM_W{1'b0}}, v} * {{PWM_W{1'b0}}, v};
        return sq[2*PWM_W-1:PWM_W];
    endfunction
`endif

    // Timebase state
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [PWM_W-1:0]   pwm_cnt_q, pwm_cnt_d;
    logic               step_s;
    logic               period_end_s;
    logic               period_tick_q;

    // Config handshake
    logic [15:0] pend_ext_s;
    logic        ch_valid_s;
    logic        accept_s;
    logic        cfg_err_q;

    // Per-channel state
    logic [CH_NUM-1:0][1:0]       shadow_mode_q, shadow_mode_d;
    logic [CH_NUM-1:0][PWM_W-1:0] shadow_duty_q, shadow_duty_d;
    logic [CH_NUM-1:0][1:0]       act_mode_q, act_mode_d;
    logic [CH_NUM-1:0][PWM_W-1:0] act_duty_q, act_duty_d;
    logic [CH_NUM-1:0][PWM_W-1:0] lvl_q, lvl_d;
    logic [CH_NUM-1:0]            dir_q, dir_d;
    logic [CH_NUM-1:0]            pending_q, pending_d;

    // Output path
    logic [CH_NUM-1:0]            on_s;
    logic [CH_NUM-1:0][PWM_W-1:0] cmp_s;
    logic [CH_NUM-1:0]            raw_s;
    logic [CH_NUM-1:0]            led_q;

    // Prescaler and period counter next state; pwm_cnt wraps naturally.
    always_comb begin
        step_s       = (presc_q == PRESC_LAST);
        period_end_s = step_s && (pwm_cnt_q == LVL_MAX);
        if (step_s) begin
            presc_d   = {PRESC_W{1'b0}};
            pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
        end else begin
            presc_d   = presc_q + PRESC_W'(1);
            pwm_cnt_d = pwm_cnt_q;
        end
    end

    // Handshake decode. pending is zero-extended to 16 bits so any 4-bit
    // cfg_ch can index it safely. Out-of-range channels are always ready.
    always_comb begin
        pend_ext_s = 16'(pending_q);
        ch_valid_s = ({1'b0, cfg_ch} < 5'(CH_NUM));
        if (ch_valid_s) begin
            cfg_ready = ~pend_ext_s[cfg_ch];
        end else begin
            cfg_ready = 1'b1;
        end
        accept_s = cfg_valid && cfg_ready;
    end

    // Per-channel next state: shadow load, boundary copy and breathe ramp.
    always_comb begin
        shadow_mode_d = shadow_mode_q;
        shadow_duty_d = shadow_duty_q;
        act_mode_d    = act_mode_q;
        act_duty_d    = act_duty_q;
        lvl_d         = lvl_q;
        dir_d         = dir_q;
        pending_d     = pending_q;
        for (int i = 0; i < CH_NUM; i++) begin
            if (accept_s && ch_valid_s && (cfg_ch == 4'(i))) begin
                shadow_mode_d[i] = cfg_mode;
                shadow_duty_d[i] = cfg_duty;
                pending_d[i]     = 1'b1;
            end else begin
                pending_d[i]     = pending_q[i];
            end
            if (period_end_s) begin
                // A write accepted in this same cycle found pending=0, so it
                // is not copied here and waits for the next boundary.
                if (pending_q[i]) begin
                    act_mode_d[i] = shadow_mode_q[i];
                    act_duty_d[i] = shadow_duty_q[i];
                    pending_d[i]  = 1'b0;
                end else begin
                    act_mode_d[i] = act_mode_q[i];
                    act_duty_d[i] = act_duty_q[i];
                end
                // Ramp only when the channel was already breathing. A
                // channel just entering BREATHE starts at level 0, going up.
                if ((act_mode_d[i] != MODE_BREATHE) || (act_mode_q[i] != MODE_BREATHE)) begin
                    lvl_d[i] = {PWM_W{1'b0}};
                    dir_d[i] = DIR_UP;
                end else begin
                    {dir_d[i], lvl_d[i]} = ramp_f(lvl_q[i], dir_q[i], act_duty_d[i]);
                end
            end else begin
                lvl_d[i] = lvl_q[i];
            end
        end
    end

    // Compare value per channel from its active mode.
    always_comb begin
        on_s  = {CH_NUM{1'b0}};
        cmp_s = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            case (act_mode_q[i])
                MODE_OFF:     cmp_s[i] = {PWM_W{1'b0}};
                MODE_ON:      on_s[i]  = 1'b1;
`ifdef LED_GAMMA_EN
                MODE_PWM:     cmp_s[i] = gamma_f(act_duty_q[i]);
                MODE_BREATHE: cmp_s[i] = gamma_f(lvl_q[i]);
`else
                MODE_PWM:     cmp_s[i] = act_duty_q[i];
                MODE_BREATHE: cmp_s[i] = lvl_q[i];
`endif
                default:      cmp_s[i] = {PWM_W{1'b0}};
            endcase
        end
    end

`ifdef LED_GAMMA_EN
    logic [CH_NUM-1:0]            on_q;
    logic [CH_NUM-1:0][PWM_W-1:0] cmp_q;
    logic [PWM_W-1:0]             cnt_dly_q;

    // Pipeline stage after the squarer; the counter is delayed alongside it.
    always_ff @(posedge clk25 or negedge fpga_rst_n) begin
        if (!fpga_rst_n) begin
            on_q      <= {CH_NUM{1'b0}};
            cmp_q     <= '0;
            cnt_dly_q <= {PWM_W{1'b0}};
        end else begin
            on_q      <= on_s;
            cmp_q     <= cmp_s;
            cnt_dly_q <= pwm_cnt_q;
        end
    end

    // Raw drive from the pipelined compare value.
    always_comb begin
        raw_s = {CH_NUM{1'b0}};
        for (int i = 0; i < CH_NUM; i++) begin
            raw_s[i] = on_q[i] | (cnt_dly_q < cmp_q[i]);
        end
    end
`else
    // Raw drive straight from the current compare value.
    always_comb begin
        raw_s = {CH_NUM{1'b0}};
        for (int i = 0; i < CH_NUM; i++) begin
            raw_s[i] = on_s[i] | (pwm_cnt_q < cmp_s[i]);
        end
    end
`endif

    // State registers: timebase, per-channel config, registered outputs.
    always_ff @(posedge clk25 or negedge fpga_rst_n) begin
        if (!fpga_rst_n) begin
            presc_q       <= {PRESC_W{1'b0}};
            pwm_cnt_q     <= {PWM_W{1'b0}};
            period_tick_q <= 1'b0;
            cfg_err_q     <= 1'b0;
            shadow_mode_q <= {CH_NUM{MODE_OFF}};
            shadow_duty_q <= '0;
            act_mode_q    <= {CH_NUM{MODE_OFF}};
            act_duty_q    <= '0;
            lvl_q         <= '0;
            dir_q         <= {CH_NUM{DIR_UP}};
            pending_q     <= {CH_NUM{1'b0}};
            led_q         <= {CH_NUM{LED_ACT_LOW}};
        end else begin
            presc_q       <= presc_d;
            pwm_cnt_q     <= pwm_cnt_d;
            period_tick_q <= period_end_s;
            cfg_err_q     <= cfg_valid && !ch_valid_s;
            shadow_mode_q <= shadow_mode_d;
            shadow_duty_q <= shadow_duty_d;
            act_mode_q    <= act_mode_d;
            act_duty_q    <= act_duty_d;
            lvl_q         <= lvl_d;
            dir_q         <= dir_d;
            pending_q     <= pending_d;
            led_q         <= raw_s ^ {CH_NUM{LED_ACT_LOW}};
        end
    end

    assign led_out     = led_q;
    assign period_tick = period_tick_q;
    assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// -----------------------------------------------------------------------------
// tb_led_pwm_ctrl
//
// Bench for led_pwm_ctrl with CH_NUM=4, PWM_W=4, PRESC_DIV=2 (32-clock period).
// The stimulus pushes the expected per-channel on-time of each PWM period
// into a queue. The monitor integrates led_out at each falling edge. At each
// period_tick it pops one record and compares the on-times and the period
// length. The tick cycle closes the window, because led_out lags the
// counter by one clock.
// -----------------------------------------------------------------------------
module tb_led_pwm_ctrl;

    logic       clk25 = 1'b0;
    logic       fpga_rst_n;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [3:0] cfg_ch;
    logic [1:0] cfg_mode;
    logic [3:0] cfg_duty;
    logic       cfg_err;
    logic [3:0] led_out;
    logic       period_tick;

    typedef struct {
        int on_clk [4];
        int idx;
    } exp_t;

    exp_t exp_q [$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   win_idx     = 1;

    led_pwm_ctrl #(
        .CH_NUM      (4),
        .PWM_W       (4),
        .PRESC_DIV   (2),
        .LED_ACT_LOW (1'b0)
    ) dut (
        .clk25       (clk25),
        .fpga_rst_n  (fpga_rst_n),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_ch      (cfg_ch),
        .cfg_mode    (cfg_mode),
        .cfg_duty    (cfg_duty),
        .cfg_err     (cfg_err),
        .led_out     (led_out),
        .period_tick (period_tick)
    );

    always #5 clk25 = ~clk25;

    task automatic chk(input string name, input int act, input int expv);
        vectors++;
        if (act != expv) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    // Monitor: integrate LED on-time and score each period at its tick.
    initial begin : monitor
        int   acc [4];
        int   cyc;
        bit   seen;
        exp_t e;
        cyc  = 0;
        seen = 1'b0;
        foreach (acc[i]) acc[i] = 0;
        forever begin
            @(negedge clk25);
            if (!fpga_rst_n) begin
                cyc  = 0;
                seen = 1'b0;
                foreach (acc[i]) acc[i] = 0;
            end else begin
                cyc++;
                for (int i = 0; i < 4; i++) acc[i] += int'(led_out[i]);
                if (period_tick) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_tick", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        for (int i = 0; i < 4; i++)
                            chk($sformatf("w%0d_ch%0d_on", e.idx, i), acc[i], e.on_clk[i]);
                        if (seen) chk($sformatf("w%0d_period", e.idx), cyc, 32);
                    end
                    seen = 1'b1;
                    cyc  = 0;
                    foreach (acc[i]) acc[i] = 0;
                end
            end
        end
    end

    task automatic wait_tick();
        int n = 0;
        do begin
            @(negedge clk25);
            n++;
        end while (!period_tick && n < 100);
        if (!period_tick) chk("tick_timeout", 0, 1);
    endtask

    // Queue the expected on-times of the window closed by the next tick, then wait for it.
    task automatic win(input int e0, input int e1, input int e2, input int e3);
        exp_t e;
        e.on_clk[0] = e0;
        e.on_clk[1] = e1;
        e.on_clk[2] = e2;
        e.on_clk[3] = e3;
        e.idx       = win_idx;
        win_idx++;
        exp_q.push_back(e);
        wait_tick();
    endtask

    task automatic cfg_write(input logic [3:0] ch, input logic [1:0] mode,
                             input logic [3:0] duty, input logic exp_rdy,
                             input string nm);
        @(negedge clk25);
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_mode  = mode;
        cfg_duty  = duty;
        #1;
        chk({nm, "_ready"}, int'(cfg_ready), int'(exp_rdy));
        @(negedge clk25);
        cfg_valid = 1'b0;
    endtask

    initial begin : stimulus
        fpga_rst_n = 1'b0;
        cfg_valid  = 1'b0;
        cfg_ch     = 4'd0;
        cfg_mode   = 2'd0;
        cfg_duty   = 4'd0;
        repeat (3) @(negedge clk25);
        #1;
        chk("rst_led", int'(led_out), 0);
        chk("rst_tick", int'(period_tick), 0);
        #1;
        fpga_rst_n = 1'b1;
        #1;
        chk("rst_ready", int'(cfg_ready), 1);
        chk("rst_err", int'(cfg_err), 0);

        // Idle after reset
        win(0, 0, 0, 0);

        // ch1 PWM duty 4, then 0, then 15
        cfg_write(4'd1, 2'd2, 4'd4, 1'b1, "ch1_d4");
        #1;
        chk("no_err_valid_ch", int'(cfg_err), 0);
        win(0, 0, 0, 0);
        win(0, 8, 0, 0);
        cfg_write(4'd1, 2'd2, 4'd0, 1'b1, "ch1_d0");
        win(0, 8, 0, 0);
        win(0, 0, 0, 0);
        cfg_write(4'd1, 2'd2, 4'd15, 1'b1, "ch1_d15");
        win(0, 0, 0, 0);
        win(0, 30, 0, 0);

        // Double write to ch0 (second refused), ch2 BREATHE step 5
        cfg_write(4'd0, 2'd2, 4'd3, 1'b1, "ch0_first");
        cfg_write(4'd0, 2'd2, 4'd9, 1'b0, "ch0_second");
        cfg_write(4'd2, 2'd3, 4'd5, 1'b1, "ch2_breathe");
        cfg_ch = 4'd0;
        #1;
        chk("ch0_ready_held", int'(cfg_ready), 0);
        win(0, 30, 0, 0);
        cfg_ch = 4'd0;
        #1;
        chk("ch0_ready_back", int'(cfg_ready), 1);
        win(6, 30, 0, 0);

        // Out-of-range channel: err pulse, nothing else changes
        cfg_write(4'd7, 2'd1, 4'd15, 1'b1, "ch7");
        #1;
        chk("cfg_err_pulse", int'(cfg_err), 1);
        @(negedge clk25);
        #1;
        chk("cfg_err_clear", int'(cfg_err), 0);

        // Breathe levels 5,10,15,10,5,0,5 -> on-time 2*lvl
        win(6, 30, 10, 0);
        win(6, 30, 20, 0);
        win(6, 30, 30, 0);
        win(6, 30, 20, 0);
        win(6, 30, 10, 0);
        win(6, 30, 0, 0);
        win(6, 30, 10, 0);

        // ch3 ON
        cfg_write(4'd3, 2'd1, 4'd0, 1'b1, "ch3_on");
        win(6, 30, 20, 0);
        win(6, 30, 30, 32);

        // Pending write to ch3, then reset mid-period
        cfg_write(4'd3, 2'd2, 4'd2, 1'b1, "ch3_pend");
        repeat (5) @(negedge clk25);
        #1;
        chk("pre_rst_led3", int'(led_out[3]), 1);
        #1;
        fpga_rst_n = 1'b0;
        #1;
        chk("mid_rst_led", int'(led_out), 0);
        chk("mid_rst_tick", int'(period_tick), 0);
        @(negedge clk25);
        @(negedge clk25);
        #2;
        fpga_rst_n = 1'b1;
        cfg_ch = 4'd3;
        #1;
        chk("post_rst_ready3", int'(cfg_ready), 1);
        win(0, 0, 0, 0);
        win(0, 0, 0, 0);

        @(negedge clk25);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
